lorenz_plotter: RTL and testbench
=================================

Name: lorenz_plotter

Overview:
- Consumer end of the Lorenz solver's state stream. Paces the solver with a step enable and decimates its 27-bit x/y/z trajectory.
- Projects each kept sample onto a 2-D screen plane, clips it, and writes one pixel per sample to the VGA pixel-memory port through a req/ack handshake.
- Also performs a full-screen clear sweep after reset or on command.

Parameters:
WIDTH, 27, state word width; signed fixed point, 7.20 format
FRAC, 20, fractional bits of x/y/z
SCALE_SHIFT, 3, screen pixels per unit = 2^SCALE_SHIFT
H_RES, 640, screen width in pixels
V_RES, 480, screen height in pixels
X_CENTER, 320, screen column for horizontal coordinate 0
Y_CENTER, 240, screen row for vertical coordinate 0 (after offset)
Z_OFFSET, 25, integer subtracted from z whenever z is on an axis
FG_COLOR, 8'hFF, trajectory pixel colour
BG_COLOR, 8'h00, clear colour

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
x, y, z  input  WIDTH each  signed solver state, valid every cycle
run  input  1  level; allows the solver to step
clear  input  1  one-cycle pulse; requests a screen clear
proj_sel  input  2  0: (x,z), 1: (y,z), 2: (x,y), 3: treated as 0; sampled at capture
decim  input  16  keep 1 of every decim steps; 0 is treated as 1
step_en  output  1  solver clock enable; solver advances on an edge where step_en=1
pix_req  output  1  pixel write request
pix_x  output  10  pixel column
pix_y  output  9  pixel row
pix_color  output  8  pixel colour
pix_ack  input  1  memory has accepted the current request this cycle
busy  output  1  high in every state except RUN
plot_count  output  16  pixels written since reset; wraps
drop_count  output  16  samples clipped since reset; wraps

Behaviour:
- Reset, asynchronous:
  - State becomes CLEAR with sweep counters at (0,0).
  - step_en=0, pix_req=0, pix_x=0, pix_y=0, pix_color=BG_COLOR.
  - plot_count=0, drop_count=0, decimation counter=0.
  - busy=1.
- State CLEAR:
  - Drive pix_req=1, pix_color=BG_COLOR, pix_x/pix_y = sweep counters.
  - On each pix_ack, advance pix_x. At H_RES-1, wrap pix_x to 0 and increment pix_y.
  - The ack at (H_RES-1, V_RES-1) ends the sweep: pix_req falls the next cycle and the state goes to RUN.
  - step_en=0 throughout. Clear writes do not change plot_count.
  - A clear pulse during CLEAR restarts the sweep at (0,0).
- State RUN:
  - step_en = run, combinational from state; no other outputs change.
  - Each cycle with step_en=1, the decimation counter increments.
  - When the counter equals max(decim,1)-1 on a step cycle:
    - The counter returns to 0.
    - x, y, z and proj_sel of that same cycle (pre-step values) are latched.
    - The state goes to PROJECT.
  - A clear pulse in RUN takes priority over a capture: go to CLEAR, with no capture.
- State PROJECT, exactly 1 cycle, step_en=0:
  - Select axes a (horizontal) and b (vertical) by proj_sel.
  - Any z axis uses z - (Z_OFFSET << FRAC), computed in WIDTH+1 bits.
  - u = a >>> (FRAC - SCALE_SHIFT); v = b >>> (FRAC - SCALE_SHIFT). Arithmetic shift, truncation toward -inf.
  - px = X_CENTER + u; py = Y_CENTER - v, in signed WIDTH+1 bits.
  - If 0 <= px < H_RES and 0 <= py < V_RES: load pix_x/pix_y, set pix_color=FG_COLOR, go to WRITE.
  - Otherwise increment drop_count and return to RUN.
- State WRITE:
  - pix_req=1 with address and colour held stable until pix_ack is sampled high.
  - On the ack cycle, plot_count increments; next cycle pix_req=0 and the state is RUN.
  - step_en=0, so the solver is frozen for the whole handshake.
  - A clear pulse during WRITE is latched as pending. After the ack the state goes to CLEAR instead of RUN.
- pix_ack while pix_req=0 is ignored.
- Latency: capture to pix_req=1 is 2 cycles.
- Minimum RUN-to-RUN time per plotted sample is 3 cycles plus the ack wait.

Test Plan:
- H_RES=8, V_RES=4, pix_ack held 1, reset released → 32 consecutive BG writes, raster order (0,0)..(7,3), then busy=0; plot_count=0.
- After clear, run=1, decim=4, x=1.0 (0x0100000), z=25.0, proj_sel=0, pix_ack=1 (defaults) → first pix_req occurs 2 cycles after the 4th step_en pulse, with pix_x=328, pix_y=240, color FF.
- x=-41.0, proj_sel=2, default geometry → px=-8 clipped, no pix_req, drop_count=1, RUN resumes the following cycle.
- pix_ack held low for 10 cycles during WRITE → pix_req, pix_x and pix_y stable, step_en=0 for all 10 cycles; plot_count increments once on ack.
- clear pulsed in WRITE before ack, then ack → plot_count increments, next state CLEAR, sweep restarts at (0,0).
- reset asserted mid-WRITE → outputs take reset values immediately, without waiting for a clock edge; CLEAR sweep restarts from (0,0) after release.

Source files
------------

// File: rtl/lorenz_plotter.sv
// lorenz_plotter: consumer end of the Lorenz solver's state stream.
// Paces the solver with step_en, keeps 1 of every decim steps, projects the kept
// (x,y,z) sample onto the screen plane, clips it and writes one pixel per sample
// through a req/ack pixel-memory port. Sweeps the whole screen with BG_COLOR after
// reset or on a clear pulse.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   x, y, z             signed 7.20 solver state, valid every cycle
//   run                 level, lets the solver step while plotting is idle
//   clear               one-cycle pulse, requests a screen clear
//   proj_sel            0:(x,z) 1:(y,z) 2:(x,y) 3:(x,z)
//   decim               keep 1 of every decim steps (0 behaves as 1)
//   step_en             solver clock enable
//   pix_req/pix_ack     pixel write handshake; pix_x/pix_y/pix_color held while req
//   busy                high whenever not in RUN
//   plot_count          pixels written since reset (wraps)
//   drop_count          samples clipped since reset (wraps)
module lorenz_plotter #(
  parameter int unsigned WIDTH       = 27,
  parameter int unsigned FRAC        = 20,
  parameter int unsigned SCALE_SHIFT = 3,
  parameter int unsigned H_RES       = 640,
  parameter int unsigned V_RES       = 480,
  parameter int unsigned X_CENTER    = 320,
  parameter int unsigned Y_CENTER    = 240,
  parameter int unsigned Z_OFFSET    = 25,
  parameter logic [7:0]  FG_COLOR    = 8'hFF,
  parameter logic [7:0]  BG_COLOR    = 8'h00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  input  logic             run,
  input  logic             clear,
  input  logic [1:0]       proj_sel,
  input  logic [15:0]      decim,
  output logic             step_en,
  output logic             pix_req,
  output logic [9:0]       pix_x,
  output logic [8:0]       pix_y,
  output logic [7:0]       pix_color,
  input  logic             pix_ack,
  output logic             busy,
  output logic [15:0]      plot_count,
  output logic [15:0]      drop_count
);

  localparam int unsigned SH = FRAC - SCALE_SHIFT;
  localparam logic signed [WIDTH:0] ZOFF = (WIDTH+1)'(Z_OFFSET << FRAC);
  localparam logic signed [WIDTH:0] XC   = (WIDTH+1)'(X_CENTER);
  localparam logic signed [WIDTH:0] YC   = (WIDTH+1)'(Y_CENTER);
  localparam logic signed [WIDTH:0] HR   = (WIDTH+1)'(H_RES);
  localparam logic signed [WIDTH:0] VR   = (WIDTH+1)'(V_RES);
  localparam logic [9:0]            XMAX = 10'(H_RES - 1);
  localparam logic [8:0]            YMAX = 9'(V_RES - 1);

  typedef enum logic [1:0] {StClear, StRun, StProject, StWrite} state_e;

  state_e           state_q, state_d;
  logic [15:0]      dcnt_q, dcnt_d;
  logic [WIDTH-1:0] xs_q, xs_d, ys_q, ys_d, zs_q, zs_d;
  logic [1:0]       psel_q, psel_d;
  logic             pix_req_q, pix_req_d;
  logic [9:0]       pix_x_q, pix_x_d;
  logic [8:0]       pix_y_q, pix_y_d;
  logic [7:0]       pix_color_q, pix_color_d;
  logic [15:0]      plot_q, plot_d, drop_q, drop_d;
  logic             clr_pend_q, clr_pend_d;
  logic             go_clear;

  // Projection datapath, working on the latched sample in WIDTH+1 bits.
  logic signed [WIDTH:0] xe, ye, ze, a, b, u, v, px, py;
  logic                  in_range;
  logic [15:0]           dmax;

  always_comb begin
    xe = {xs_q[WIDTH-1], xs_q};
    ye = {ys_q[WIDTH-1], ys_q};
    ze = {zs_q[WIDTH-1], zs_q} - ZOFF;
    unique case (psel_q)
      2'd1:    begin a = ye; b = ze; end
      2'd2:    begin a = xe; b = ye; end
      default: begin a = xe; b = ze; end
    endcase
    u  = a >>> SH;
    v  = b >>> SH;
    px = XC + u;
    py = YC - v;
    in_range = !px[WIDTH] && (px < HR) && !py[WIDTH] && (py < VR);
  end

  assign dmax = (decim == 16'd0) ? 16'd0 : decim - 16'd1;

  always_comb begin
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    xs_d        = xs_q;
    ys_d        = ys_q;
    zs_d        = zs_q;
    psel_d      = psel_q;
    pix_req_d   = pix_req_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_color_d = pix_color_q;
    plot_d      = plot_q;
    drop_d      = drop_q;
    clr_pend_d  = clr_pend_q;
    go_clear    = 1'b0;
    step_en     = 1'b0;

    unique case (state_q)
      StClear: begin
        if (clear) begin
          go_clear = 1'b1;
        end else if (pix_req_q && pix_ack) begin
          if (pix_x_q == XMAX) begin
            pix_x_d = 10'd0;
            if (pix_y_q == YMAX) begin
              pix_y_d   = 9'd0;
              pix_req_d = 1'b0;
              state_d   = StRun;
            end else begin
              pix_y_d = pix_y_q + 9'd1;
            end
          end else begin
            pix_x_d = pix_x_q + 10'd1;
          end
        end else begin
          // Raises the request on the first cycle after reset.
          pix_req_d = 1'b1;
        end
      end
      StRun: begin
        step_en = run;
        if (clear) begin
          go_clear = 1'b1;
        end else if (run) begin
          if (dcnt_q == dmax) begin
            dcnt_d  = 16'd0;
            xs_d    = x;
            ys_d    = y;
            zs_d    = z;
            psel_d  = proj_sel;
            state_d = StProject;
          end else begin
            dcnt_d = dcnt_q + 16'd1;
          end
        end
      end
      StProject: begin
        clr_pend_d = clr_pend_q | clear;
        if (in_range) begin
          pix_x_d     = px[9:0];
          pix_y_d     = py[8:0];
          pix_color_d = FG_COLOR;
          pix_req_d   = 1'b1;
          state_d     = StWrite;
        end else begin
          drop_d = drop_q + 16'd1;
          if (clr_pend_d) go_clear = 1'b1;
          else            state_d  = StRun;
        end
      end
      StWrite: begin
        clr_pend_d = clr_pend_q | clear;
        if (pix_ack) begin
          plot_d = plot_q + 16'd1;
          if (clr_pend_d) begin
            go_clear = 1'b1;
          end else begin
            pix_req_d = 1'b0;
            state_d   = StRun;
          end
        end
      end
      default: state_d = StClear;
    endcase

    if (go_clear) begin
      state_d     = StClear;
      pix_x_d     = 10'd0;
      pix_y_d     = 9'd0;
      pix_req_d   = 1'b1;
      pix_color_d = BG_COLOR;
      clr_pend_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StClear;
      dcnt_q      <= 16'd0;
      xs_q        <= '0;
      ys_q        <= '0;
      zs_q        <= '0;
      psel_q      <= 2'd0;
      pix_req_q   <= 1'b0;
      pix_x_q     <= 10'd0;
      pix_y_q     <= 9'd0;
      pix_color_q <= BG_COLOR;
      plot_q      <= 16'd0;
      drop_q      <= 16'd0;
      clr_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      xs_q        <= xs_d;
      ys_q        <= ys_d;
      zs_q        <= zs_d;
      psel_q      <= psel_d;
      pix_req_q   <= pix_req_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_color_q <= pix_color_d;
      plot_q      <= plot_d;
      drop_q      <= drop_d;
      clr_pend_q  <= clr_pend_d;
    end
  end

  assign pix_req    = pix_req_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_color  = pix_color_q;
  assign busy       = (state_q != StRun);
  assign plot_count = plot_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_lorenz_plotter.sv
// Testbench for lorenz_plotter. A tiny 8x4 instance checks the raster clear sweep;
// a 64x32 instance (centre 32,16, otherwise default scaling) keeps every clear
// sweep short while exercising projection, clipping, pacing and handshakes.
module tb_lorenz_plotter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, rst_s, ack, ack_s, run, clear;
  logic signed [26:0] x, y, z;
  logic [1:0]         proj_sel;
  logic [15:0]        decim;

  logic        step_en, pix_req, busy;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [7:0]  pix_color;
  logic [15:0] plot_count, drop_count;

  logic        step_en_s, pix_req_s, busy_s;
  logic [9:0]  pix_x_s;
  logic [8:0]  pix_y_s;
  logic [7:0]  pix_color_s;
  logic [15:0] plot_count_s, drop_count_s;

  lorenz_plotter #(
    .H_RES(64), .V_RES(32), .X_CENTER(32), .Y_CENTER(16)
  ) dut (
    .clk(clk), .reset(rst), .x(x), .y(y), .z(z), .run(run), .clear(clear),
    .proj_sel(proj_sel), .decim(decim), .step_en(step_en), .pix_req(pix_req),
    .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .pix_ack(ack), .busy(busy),
    .plot_count(plot_count), .drop_count(drop_count)
  );

  lorenz_plotter #(
    .H_RES(8), .V_RES(4), .X_CENTER(4), .Y_CENTER(2)
  ) dut_s (
    .clk(clk), .reset(rst_s), .x(x), .y(y), .z(z), .run(1'b0), .clear(1'b0),
    .proj_sel(proj_sel), .decim(decim), .step_en(step_en_s), .pix_req(pix_req_s),
    .pix_x(pix_x_s), .pix_y(pix_y_s), .pix_color(pix_color_s), .pix_ack(ack_s),
    .busy(busy_s), .plot_count(plot_count_s), .drop_count(drop_count_s)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_plot = 0;
  int exp_drop = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Value in eighths of a unit -> 7.20 fixed point (one eighth = one pixel).
  function automatic logic signed [26:0] fx(input int q8);
    return 27'(q8 * (2 ** 17));
  endfunction

  typedef struct {
    logic signed [26:0] vx, vy, vz;
    logic [1:0]         sel;
    logic               hit;
    int                 ex, ey;
  } vec_t;

  vec_t vecs[10];

  task automatic wait_idle(input string name, input int limit);
    int c = 0;
    while (busy && c < limit) begin
      @(negedge clk);
      c++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  // Drive one sample with decim=1 and a single run cycle: capture on the next edge.
  task automatic capture(input vec_t v);
    @(negedge clk);
    x = v.vx; y = v.vy; z = v.vz; proj_sel = v.sel; decim = 16'd1; run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k, c, steps;
    logic [9:0] hx;
    logic [8:0] hy;

    rst = 1'b1; rst_s = 1'b1; ack = 1'b1; ack_s = 1'b1; run = 1'b0; clear = 1'b0;
    x = '0; y = '0; z = '0; proj_sel = 2'd0; decim = 16'd1;

    // Expected vectors on the 64x32 instance: px = 32 + floor(8a), py = 16 - floor(8b).
    vecs[0] = '{fx(8),          27'sd0,          fx(200),  2'd0, 1'b1, 40, 16};
    vecs[1] = '{27'sd0,         fx(-16),         fx(216),  2'd1, 1'b1, 16, 0};
    vecs[2] = '{fx(31),         fx(-15),         27'sd0,   2'd2, 1'b1, 63, 31};
    vecs[3] = '{fx(32),         27'sd0,          27'sd0,   2'd2, 1'b0, 0, 0};
    vecs[4] = '{fx(-32),        27'sd0,          fx(200),  2'd3, 1'b1, 0, 16};
    vecs[5] = '{fx(-32) - 27'sd1, 27'sd0,        fx(200),  2'd0, 1'b0, 0, 0};
    vecs[6] = '{27'sd0,         27'sd0,          fx(184),  2'd0, 1'b0, 0, 0};
    vecs[7] = '{fx(-40),        27'sd0,          27'sd0,   2'd2, 1'b0, 0, 0};
    vecs[8] = '{27'sd0,         27'(1 << 16),    fx(200),  2'd1, 1'b1, 32, 16};
    vecs[9] = '{27'sd0,         27'sd0, fx(200) - 27'(1 << 16), 2'd0, 1'b1, 32, 17};

    #12;
    check("rst_busy",  32'(busy),       32'd1);
    check("rst_req",   32'(pix_req),    32'd0);
    check("rst_step",  32'(step_en),    32'd0);
    check("rst_xy",    32'({pix_x, pix_y}), 32'd0);
    check("rst_color", 32'(pix_color),  32'h00);
    check("rst_plot",  32'(plot_count), 32'd0);
    check("rst_drop",  32'(drop_count), 32'd0);

    @(negedge clk);
    rst = 1'b0; rst_s = 1'b0;

    // Raster-order clear sweep on the 8x4 instance.
    k = 0; c = 0;
    while (k < 32 && c < 100) begin
      @(negedge clk);
      c++;
      if (pix_req_s) begin
        hx = 10'(k % 8);
        hy = 9'(k / 8);
        check("sweep_pos", 32'({pix_x_s, pix_y_s}), 32'({hx, hy}));
        check("sweep_color", 32'(pix_color_s), 32'h00);
        k++;
      end
    end
    check("sweep_count", 32'(k), 32'd32);
    @(negedge clk);
    check("sweep_req_low", 32'(pix_req_s), 32'd0);
    check("sweep_idle", 32'(busy_s), 32'd0);
    check("sweep_plot", 32'(plot_count_s), 32'd0);

    wait_idle("init_clear_done", 3000);
    check("init_plot", 32'(plot_count), 32'd0);

    // Table-driven projection/clipping vectors.
    for (int i = 0; i < 10; i++) begin
      capture(vecs[i]);
      @(negedge clk);
      check("proj_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("vec_req", 32'(pix_req), 32'(vecs[i].hit));
      if (vecs[i].hit) begin
        check("vec_x", 32'(pix_x), 32'(vecs[i].ex));
        check("vec_y", 32'(pix_y), 32'(vecs[i].ey));
        check("vec_color", 32'(pix_color), 32'hFF);
        exp_plot++;
      end else begin
        exp_drop++;
      end
      check("vec_drop", 32'(drop_count), 32'(exp_drop));
      @(negedge clk);
      check("vec_idle", 32'(busy), 32'd0);
      check("vec_plot", 32'(plot_count), 32'(exp_plot));
    end

    // Decimation by 4: pixel request two cycles after the 4th step pulse.
    @(negedge clk);
    x = fx(8); y = '0; z = fx(200); proj_sel = 2'd0; decim = 16'd4; run = 1'b1; ack = 1'b1;
    #1;
    steps = 0; c = 0;
    while (c < 20) begin
      if (step_en) steps++;
      if (steps == 4) break;
      @(negedge clk);
      c++;
    end
    check("dec_steps", 32'(steps), 32'd4);
    @(negedge clk);
    check("dec_proj_req", 32'(pix_req), 32'd0);
    check("dec_proj_step", 32'(step_en), 32'd0);
    @(negedge clk);
    run = 1'b0;
    check("dec_req", 32'(pix_req), 32'd1);
    check("dec_xy", 32'({pix_x, pix_y}), 32'({10'd40, 9'd16}));
    check("dec_color", 32'(pix_color), 32'hFF);
    exp_plot++;
    @(negedge clk);
    check("dec_plot", 32'(plot_count), 32'(exp_plot));

    // Ack held low for 10 cycles in WRITE.
    ack = 1'b0;
    capture(vecs[0]);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_req", 32'(pix_req), 32'd1);
      check("stall_xy", 32'({pix_x, pix_y}), 32'({10'd40, 9'd16}));
      check("stall_step", 32'(step_en), 32'd0);
      check("stall_plot", 32'(plot_count), 32'(exp_plot));
    end
    ack = 1'b1;
    exp_plot++;
    @(negedge clk);
    check("stall_done_req", 32'(pix_req), 32'd0);
    check("stall_done_plot", 32'(plot_count), 32'(exp_plot));
    @(negedge clk);
    check("stall_once", 32'(plot_count), 32'(exp_plot));

    // Clear pulse during WRITE, then ack: pixel counted, sweep restarts at (0,0).
    ack = 1'b0;
    capture(vecs[0]);
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    check("clrw_hold_req", 32'(pix_req), 32'd1);
    check("clrw_hold_plot", 32'(plot_count), 32'(exp_plot));
    ack = 1'b1;
    exp_plot++;
    @(negedge clk);
    check("clrw_plot", 32'(plot_count), 32'(exp_plot));
    check("clrw_busy", 32'(busy), 32'd1);
    check("clrw_req", 32'(pix_req), 32'd1);
    check("clrw_xy0", 32'({pix_x, pix_y}), 32'd0);
    check("clrw_color", 32'(pix_color), 32'h00);
    @(negedge clk);
    check("clrw_xy1", 32'({pix_x, pix_y}), 32'({10'd1, 9'd0}));
    wait_idle("clrw_done", 3000);
    check("clrw_plot_after", 32'(plot_count), 32'(exp_plot));

    // Asynchronous reset in the middle of WRITE.
    ack = 1'b0;
    capture(vecs[2]);
    @(negedge clk);
    @(negedge clk);
    check("rstw_req_before", 32'(pix_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rstw_req", 32'(pix_req), 32'd0);
    check("rstw_xy", 32'({pix_x, pix_y}), 32'd0);
    check("rstw_color", 32'(pix_color), 32'h00);
    check("rstw_busy", 32'(busy), 32'd1);
    check("rstw_step", 32'(step_en), 32'd0);
    check("rstw_plot", 32'(plot_count), 32'd0);
    check("rstw_drop", 32'(drop_count), 32'd0);
    exp_plot = 0;
    exp_drop = 0;
    @(negedge clk);
    rst = 1'b0;
    ack = 1'b1;
    @(negedge clk);
    check("rstw_sweep0", 32'({pix_req, pix_x, pix_y}), 32'({1'b1, 10'd0, 9'd0}));
    @(negedge clk);
    check("rstw_sweep1", 32'({pix_req, pix_x, pix_y}), 32'({1'b1, 10'd1, 9'd0}));
    wait_idle("rstw_done", 3000);
    check("rstw_plot_after", 32'(plot_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
